// File: rtl/shift_exec_stage.sv
// Two-stage pipelined MIPS shift execute unit (SLL/SRL/SRA/SLLV/SRLV/SRAV) with valid/ready on both sides.
// Optional ROTATE_EN macro adds ROTR/ROTRV decode on funct 02h/06h when rot_sel is set.
module shift_exec_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       funct,
   input  logic [4:0]       sa,
   input  logic             rot_sel,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   input  logic [4:0]       rd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [4:0]       out_rd,
   output logic             out_we,
   output logic             out_illegal,
   output logic [CNT_W-1:0] retired_cnt
);

   function automatic logic [31:0] barrel(input logic [31:0] v, input logic [4:0] amt,
                                          input logic left, input logic lgc);
      logic signed [31:0] sv;
      sv = signed'(v);
      if (left)     return v << amt;
      else if (lgc) return v >> amt;
      else          return unsigned'(sv >>> amt);
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] amt);
      if (amt == 5'd0) return v;
      return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
   endfunction

   logic        s1_valid_q, s1_valid_d;
   logic [4:0]  s1_amt_q, s1_rd_q;
   logic        s1_left_q, s1_logic_q, s1_legal_q, s1_rot_q;
   logic [31:0] s1_rt_q;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_result_q, out_result_d, shift_res;
   logic [4:0]  out_rd_q;
   logic        out_we_q, out_illegal_q;
   logic [CNT_W-1:0] retired_q;
   logic        in_xfer, out_xfer, s1_move, rot_dec;

   assign in_ready = ~s1_valid_q | ~out_valid_q | out_ready;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid_q & out_ready;
   assign s1_move  = s1_valid_q & (~out_valid_q | out_ready);

`ifdef ROTATE_EN
   assign rot_dec = rot_sel & (funct[1:0] == 2'b10);
`else
   assign rot_dec = 1'b0;
   logic unused_rot;
   assign unused_rot = rot_sel;
`endif
   logic unused_rs;
   assign unused_rs = ^rs_val[31:5];

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_xfer)      s1_valid_d = 1'b1;
      else if (s1_move) s1_valid_d = 1'b0;
      out_valid_d = out_valid_q;
      if (s1_move)       out_valid_d = 1'b1;
      else if (out_xfer) out_valid_d = 1'b0;
      shift_res = barrel(s1_rt_q, s1_amt_q, s1_left_q, s1_logic_q);
      if (s1_rot_q) shift_res = rotr(s1_rt_q, s1_amt_q);
      out_result_d = s1_legal_q ? shift_res : 32'h0;
   end

   // S1: decode register
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
      end
      if (in_xfer) begin
         s1_amt_q   <= funct[2] ? rs_val[4:0] : sa;
         s1_left_q  <= (funct[1:0] == 2'b00);
         s1_logic_q <= (funct[1:0] != 2'b11);
         s1_legal_q <= (funct[5:3] == 3'b000) && (funct[1:0] != 2'b01);
         s1_rot_q   <= rot_dec;
         s1_rt_q    <= rt_val;
         s1_rd_q    <= rd;
      end
   end

   // S2: output register, holds while downstream stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         out_result_q  <= 32'h0;
         out_rd_q      <= 5'd0;
         out_we_q      <= 1'b0;
         out_illegal_q <= 1'b0;
         retired_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (s1_move) begin
            out_result_q  <= out_result_d;
            out_rd_q      <= s1_rd_q;
            out_we_q      <= s1_legal_q & (s1_rd_q != 5'd0);
            out_illegal_q <= ~s1_legal_q;
         end
         if (out_xfer) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_rd      = out_rd_q;
   assign out_we      = out_we_q;
   assign out_illegal = out_illegal_q;
   assign retired_cnt = retired_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed testbench for shift_exec_stage; rotate expectation follows the ROTATE_EN macro.
module tb_shift_exec_stage;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, rot_sel, out_valid, out_ready, out_we, out_illegal;
   logic [5:0]  funct;
   logic [4:0]  sa, rd, out_rd;
   logic [31:0] rs_val, rt_val, out_result;
   logic [15:0] retired_cnt;
   int          tests_run = 0;
   int          tests_failed = 0;

   shift_exec_stage #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .funct(funct), .sa(sa), .rot_sel(rot_sel), .rs_val(rs_val), .rt_val(rt_val),
      .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] f, input logic [4:0] s, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] r, input logic rot);
      funct = f; sa = s; rs_val = rs; rt_val = rt; rd = r; rot_sel = rot; in_valid = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [4:0] s,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] r,
                         input logic rot, input logic [31:0] er, input logic ewe, input logic eill);
      @(negedge clk);
      drive(f, s, rs, rt, r, rot);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_lat1"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_result"}, out_result, er);
      check({tag, "_rd"}, out_rd, r);
      check({tag, "_we"}, out_we, ewe);
      check({tag, "_illegal"}, out_illegal, eill);
      @(negedge clk);
      check({tag, "_drain"}, out_valid, 0);
   endtask

   logic [31:0] b2b_res [4] = '{32'h0000_0002, 32'h0000_000F, 32'hFF00_0000, 32'h0000_0008};

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      funct = '0; sa = '0; rs_val = '0; rt_val = '0; rd = '0; rot_sel = 1'b0;
      do_reset();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", out_result, 0);
      check("rst_rd", out_rd, 0);
      check("rst_we", out_we, 0);
      check("rst_illegal", out_illegal, 0);
      check("rst_cnt", retired_cnt, 0);
      check("rst_in_ready", in_ready, 1);

      out_ready = 1'b1;
      run_op("sll",   6'h00, 5'd4,  32'h0, 32'h0000_000F, 5'd3, 1'b0, 32'h0000_00F0, 1'b1, 1'b0);
      run_op("srav",  6'h07, 5'd0,  32'h0000_0021, 32'h8000_0000, 5'd5, 1'b0, 32'hC000_0000, 1'b1, 1'b0);
      run_op("srlv",  6'h06, 5'd0,  32'h0000_0021, 32'h8000_0000, 5'd5, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
      run_op("ill",   6'h20, 5'd3,  32'h0, 32'h1234_5678, 5'd4, 1'b0, 32'h0, 1'b0, 1'b1);
      run_op("rd0",   6'h00, 5'd1,  32'h0, 32'h0000_0001, 5'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
      run_op("sra31", 6'h03, 5'd31, 32'h0, 32'h8000_0000, 5'd9, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("amt0",  6'h02, 5'd0,  32'h0, 32'hA5A5_A5A5, 5'd10, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b0);
`ifdef ROTATE_EN
      run_op("rot",   6'h02, 5'd8,  32'h0, 32'h1234_5678, 5'd11, 1'b1, 32'h7812_3456, 1'b1, 1'b0);
`else
      run_op("rot",   6'h02, 5'd8,  32'h0, 32'h1234_5678, 5'd11, 1'b1, 32'h0012_3456, 1'b1, 1'b0);
`endif
      check("cnt_singles", retired_cnt, 8);

      // Back-to-back: four ops on consecutive cycles
      do_reset();
      @(negedge clk);
      check("b2b_cnt0", retired_cnt, 0);
      fork
         begin
            drive(6'h00, 5'd1, 32'h0, 32'h0000_0001, 5'd1, 1'b0);
            @(posedge clk); #1 drive(6'h02, 5'd4, 32'h0, 32'h0000_00F0, 5'd2, 1'b0);
            @(posedge clk); #1 drive(6'h03, 5'd4, 32'h0, 32'hF000_0000, 5'd3, 1'b0);
            @(posedge clk); #1 drive(6'h04, 5'd0, 32'h0000_0003, 32'h0000_0001, 5'd4, 1'b0);
            @(posedge clk); #1 in_valid = 1'b0;
         end
         begin
            for (int w = 0; w < 10 && !out_valid; w++) @(negedge clk);
            check("b2b_start", out_valid, 1);
            for (int i = 0; i < 4; i++) begin
               check($sformatf("b2b_valid%0d", i), out_valid, 1);
               check($sformatf("b2b_result%0d", i), out_result, b2b_res[i]);
               check($sformatf("b2b_rd%0d", i), out_rd, 32'(i + 1));
               @(negedge clk);
            end
         end
      join
      check("b2b_cnt4", retired_cnt, 4);

      // Stall: two ops with out_ready low
      out_ready = 1'b0;
      drive(6'h00, 5'd2, 32'h0, 32'h0000_0001, 5'd7, 1'b0);
      @(posedge clk); #1 drive(6'h02, 5'd1, 32'h0, 32'h0000_0100, 5'd8, 1'b0);
      @(posedge clk); #1 in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("stall_in_ready%0d", c), in_ready, 0);
         check($sformatf("stall_valid%0d", c), out_valid, 1);
         check($sformatf("stall_result%0d", c), out_result, 32'h0000_0004);
         check($sformatf("stall_rd%0d", c), out_rd, 7);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_b_valid", out_valid, 1);
      check("stall_b_result", out_result, 32'h0000_0080);
      check("stall_b_rd", out_rd, 8);
      @(negedge clk);
      check("stall_drain", out_valid, 0);
      check("stall_cnt", retired_cnt, 6);

      // Reset mid-stall with both stages full
      out_ready = 1'b0;
      drive(6'h00, 5'd1, 32'h0, 32'h0000_0003, 5'd1, 1'b0);
      @(posedge clk); #1 drive(6'h00, 5'd2, 32'h0, 32'h0000_0003, 5'd2, 1'b0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("mid_valid_pre", out_valid, 1);
      check("mid_in_ready_pre", in_ready, 0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_cnt", retired_cnt, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_result", out_result, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_no_ghost", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1, "timeout");
   end
endmodule
